// File: rtl/cardinal_nic_pkg.sv
// cardinal_nic_pkg
//   Shared constants for the cardinal NIC: the processor-visible register
//   map, the packet bit that selects the virtual channel, and the default
//   packet/address widths.
package cardinal_nic_pkg;

    localparam int NIC_DATA_WIDTH = 64;
    localparam int NIC_ADDR_WIDTH = 2;

    // Processor-visible register addresses
    localparam logic [1:0] NIC_IN_BUF   = 2'd0;  // input buffer, read-only
    localparam logic [1:0] NIC_IN_STAT  = 2'd1;  // input status, read-only
    localparam logic [1:0] NIC_OUT_BUF  = 2'd2;  // output buffer, write-only
    localparam logic [1:0] NIC_OUT_STAT = 2'd3;  // output status, read-only

    // Packet bit (big-endian index) carrying the virtual-channel tag
    localparam int VC_BIT = 0;

endpackage

// File: rtl/nic_chan_buf.sv
// nic_chan_buf
//   One single-entry channel buffer: a DATA_WIDTH packet register plus a
//   full flag. A load captures i_data and sets full; a clear drops full and
//   leaves the stale data in place. The surrounding logic guarantees load
//   and clear are never asserted together.
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset (data and flag cleared)
//   i_load   in   capture i_data, set full
//   i_clear  in   clear full
//   i_data   in   packet to capture
//   o_data   out  stored packet
//   o_full   out  buffer holds an unconsumed packet
module nic_chan_buf #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_clear,
    input  logic [0:DATA_WIDTH-1] i_data,
    output logic [0:DATA_WIDTH-1] o_data,
    output logic                  o_full
);

    logic [0:DATA_WIDTH-1] r_data;
    logic                  r_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_full <= 1'b1;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_data;
    assign o_full = r_full;

endmodule

// File: rtl/cardinal_nic.sv
// cardinal_nic
//   Network interface between one cardinal processor and its mesh router.
//   Holds one router->PE input buffer and one PE->router output buffer,
//   each with a full flag the processor can poll.
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   addr               NIC register select (0 in buf, 1 in stat, 2 out buf, 3 out stat)
//   d_in               processor write data
//   d_out              processor read data, combinational, 0 when not reading
//   nicEn, nicWrEn     access enable / write select
//   net_si, net_di     router offers a packet into the NIC
//   net_ri             NIC input buffer can accept a packet
//   net_so, net_do     NIC sends a packet to the router
//   net_ro             router output-side buffer ready
//   net_polarity       router's current virtual-channel phase
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int DATA_WIDTH = NIC_DATA_WIDTH,
    parameter int ADDR_WIDTH = NIC_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:ADDR_WIDTH-1] addr,
    input  logic [0:DATA_WIDTH-1] d_in,
    output logic [0:DATA_WIDTH-1] d_out,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic                  w_rd;
    logic                  w_wr;
    logic                  w_in_load;
    logic                  w_in_clear;
    logic                  w_out_load;
    logic                  w_in_full;
    logic                  w_out_full;
    logic                  w_vc;
    logic [0:DATA_WIDTH-1] w_in_buf;
    logic [0:DATA_WIDTH-1] w_out_buf;

    assign w_rd = nicEn & ~nicWrEn;
    assign w_wr = nicEn &  nicWrEn;

    // Router fill only while empty; a send while full is a protocol
    // violation and is simply ignored. Fill and read-clear cannot overlap
    // because net_ri is low whenever the buffer is full.
    assign w_in_load  = net_si & ~w_in_full;
    assign w_in_clear = w_rd & (addr == NIC_IN_BUF) & w_in_full;

    // A write while full (including the cycle the packet is leaving) is dropped.
    assign w_out_load = w_wr & (addr == NIC_OUT_BUF) & ~w_out_full;

    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_in_chan (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_in_load),
        .i_clear (w_in_clear),
        .i_data  (net_di),
        .o_data  (w_in_buf),
        .o_full  (w_in_full)
    );

    // The output buffer empties on any cycle the packet is accepted.
    nic_chan_buf #(.DATA_WIDTH(DATA_WIDTH)) u_out_chan (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_out_load),
        .i_clear (net_so),
        .i_data  (d_in),
        .o_data  (w_out_buf),
        .o_full  (w_out_full)
    );

    // The packet only leaves in the router phase matching its VC tag;
    // otherwise it waits indefinitely.
    assign w_vc   = w_out_buf[VC_BIT];
    assign net_so = w_out_full & net_ro & (net_polarity == w_vc);
    assign net_ri = ~w_in_full;
    assign net_do = w_out_buf;

    always_comb begin
        d_out = '0;
        if (w_rd) begin
            case (addr)
                NIC_IN_BUF:   d_out = w_in_buf;
                NIC_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, w_in_full};
                NIC_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, w_out_full};
                default:      d_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:1]  addr;
    logic [0:63] d_in;
    logic [0:63] d_out;
    logic        nicEn, nicWrEn;
    logic        net_si, net_ri;
    logic [0:63] net_di;
    logic        net_so, net_ro;
    logic [0:63] net_do;
    logic        net_polarity;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    localparam logic [63:0] PKT_IN  = 64'hA5A5_0000_0000_0001;
    localparam logic [63:0] PKT_IN2 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_OUT = 64'h8000_0000_0000_00FF;
    localparam logic [63:0] PKT_A   = 64'h0000_0000_0000_0011;
    localparam logic [63:0] PKT_B   = 64'hFFFF_0000_FFFF_0000;

    cardinal_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_val(input logic [63:0] e);
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [63:0] obs);
        logic [63:0] e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic idle;
        nicEn = 1'b0; nicWrEn = 1'b0; net_si = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a; #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d; #1;
    endtask

    initial begin
        reset = 1'b1; addr = '0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
        tick;

        // Reset state
        #1;
        expect_val(64'h0); check("rst_dout_idle", d_out);
        expect_val(64'h1); check("rst_net_ri", net_ri);
        expect_val(64'h0); check("rst_net_so", net_so);
        expect_val(64'h0); check("rst_net_do", net_do);
        rd(2'd1); expect_val(64'h0); check("rst_in_stat", d_out);
        rd(2'd3); expect_val(64'h0); check("rst_out_stat", d_out);

        // Write strobe without enable has no effect
        tick;
        nicEn = 1'b0; nicWrEn = 1'b1; addr = 2'd2; d_in = PKT_B;
        tick;
        idle; rd(2'd3); expect_val(64'h0); check("wr_noen_stat", d_out);
        expect_val(64'h0); check("wr_noen_do", net_do);

        // Router fill
        tick;
        idle; net_si = 1'b1; net_di = PKT_IN;
        tick;
        net_si = 1'b0; #1;
        expect_val(64'h0); check("fill_net_ri", net_ri);
        rd(2'd1); expect_val(64'h1); check("fill_in_stat", d_out);
        rd(2'd0); expect_val(PKT_IN); check("fill_in_buf", d_out);
        tick;
        idle; #1;
        expect_val(64'h1); check("clr_net_ri", net_ri);
        rd(2'd1); expect_val(64'h0); check("clr_in_stat", d_out);
        rd(2'd0); expect_val(PKT_IN); check("stale_in_buf", d_out);
        tick;
        idle; rd(2'd1); expect_val(64'h0); check("stale_no_state", d_out);

        // Processor send, matching phase; a write in the send cycle is dropped
        tick;
        net_ro = 1'b1; net_polarity = 1'b1;
        wr(2'd2, PKT_OUT);
        expect_val(64'h0); check("send_so_before", net_so);
        tick;
        idle; #1;
        expect_val(64'h1); check("send_so", net_so);
        expect_val(PKT_OUT); check("send_do", net_do);
        rd(2'd3); expect_val(64'h1); check("send_out_stat", d_out);
        wr(2'd2, PKT_B);
        tick;
        idle; #1;
        expect_val(64'h0); check("sent_so", net_so);
        expect_val(PKT_OUT); check("sent_do_kept", net_do);
        rd(2'd3); expect_val(64'h0); check("sent_out_stat", d_out);

        // Polarity hold
        tick;
        net_polarity = 1'b0;
        wr(2'd2, PKT_OUT);
        tick;
        idle;
        for (int i = 0; i < 5; i++) begin
            #1;
            expect_val(64'h0); check("hold_so", net_so);
            rd(2'd3); expect_val(64'h1); check("hold_out_stat", d_out);
            tick;
            idle;
        end
        net_polarity = 1'b1; #1;
        expect_val(64'h1); check("flip_so", net_so);
        tick;
        #1;
        expect_val(64'h0); check("flip_so_once", net_so);

        // Output overflow while router not ready
        tick;
        net_ro = 1'b0; net_polarity = 1'b0;
        wr(2'd2, PKT_A);
        tick;
        wr(2'd2, PKT_B);
        tick;
        idle; #1;
        expect_val(PKT_A); check("ovf_do_first", net_do);
        rd(2'd3); expect_val(64'h1); check("ovf_out_stat", d_out);

        // Input overflow: a second router send while full is ignored
        tick;
        idle; net_si = 1'b1; net_di = PKT_IN2;
        tick;
        net_di = PKT_B;
        tick;
        idle; rd(2'd0); expect_val(PKT_IN2); check("ovf_in_buf", d_out);
        rd(2'd1); expect_val(64'h1); check("ovf_in_stat", d_out);

        // Asynchronous reset mid-cycle with both buffers full
        tick;
        idle; net_ro = 1'b1; net_polarity = 1'b0; #1;
        expect_val(64'h1); check("pre_rst_so", net_so);
        expect_val(64'h0); check("pre_rst_ri", net_ri);
        reset = 1'b1; #1;
        expect_val(64'h0); check("arst_so", net_so);
        expect_val(64'h1); check("arst_ri", net_ri);
        expect_val(64'h0); check("arst_do", net_do);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = 2'd1; #1;
        expect_val(64'h0); check("arst_in_stat", d_out);
        addr = 2'd3; #1;
        expect_val(64'h0); check("arst_out_stat", d_out);
        tick;
        idle; reset = 1'b0;
        tick;
        rd(2'd0); expect_val(64'h0); check("post_rst_in_buf", d_out);

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
